// File: rtl/memory_cycle_lsu.sv
// MEM stage of the RV32I pipeline: data-memory load/store handshake, byte-lane
// steering, load extension, fault detection and the MEM/WB pipeline register.
module memory_cycle_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic [4:0]  RD_M,
    input  logic [2:0]  funct3M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALU_ResultM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        FaultM,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] PCPlus4W,
    output logic        dbg_state
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        access, is_store, misaligned, illegal, bad_access, good_access;
    logic        timeout, req_raw;
    logic [1:0]  off;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;

    logic        reg_write_w_q, reg_write_w_d;
    logic        result_src_w_q, result_src_w_d;
    logic [4:0]  rd_w_q, rd_w_d;
    logic [31:0] read_data_w_q, read_data_w_d;
    logic [31:0] alu_result_w_q, alu_result_w_d;
    logic [31:0] pc_plus4_w_q, pc_plus4_w_d;

    // Access decode: a faulting access never reaches the memory port.
    always_comb begin
        access     = MemWriteM | ResultSrcM;
        is_store   = MemWriteM;
        off        = ALU_ResultM[1:0];
        misaligned = ((funct3M[1:0] == 2'b01) & off[0]) |
                     ((funct3M[1:0] == 2'b10) & (off != 2'b00));
        if (is_store)
            illegal = (funct3M != 3'b000) & (funct3M != 3'b001) & (funct3M != 3'b010);
        else
            illegal = (funct3M == 3'b011) | (funct3M == 3'b110) | (funct3M == 3'b111);
        bad_access  = access & (misaligned | illegal);
        good_access = access & ~bad_access;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // An ack in the last WAIT cycle still completes the access; the abort only fires without one.
    always_comb begin
        timeout = (state_q == S_WAIT) & ~dmem_ack & (cnt_q == CNT_LAST);
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (good_access & ~dmem_ack) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (dmem_ack | timeout)
                    state_d = S_IDLE;
                else
                    cnt_d = cnt_q + CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake: dmem_req rises with a valid access and stays high until the cycle
    // dmem_ack is seen; the transfer happens in that cycle (read data valid with ack).
    // Reset gates req/stall/fault so they drop the moment rst falls.
    always_comb begin
        req_raw   = ((state_q == S_IDLE) & good_access) | ((state_q == S_WAIT) & ~timeout);
        dmem_req  = rst & req_raw;
        StallM    = rst & req_raw & ~dmem_ack;
        FaultM    = rst & (((state_q == S_IDLE) & bad_access) | timeout);
        dbg_state = state_q;
    end

    always_comb begin
        dmem_we    = MemWriteM;
        dmem_addr  = {ALU_ResultM[31:2], 2'b00};
        dmem_be    = 4'b1111;
        dmem_wdata = WriteDataM;
        if (is_store) begin
            case (funct3M[1:0])
                2'b00: begin
                    dmem_be    = 4'b0001 << off;
                    dmem_wdata = {4{WriteDataM[7:0]}};
                end
                2'b01: begin
                    dmem_be    = 4'b0011 << off;
                    dmem_wdata = {2{WriteDataM[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = WriteDataM;
                end
            endcase
        end
    end

    always_comb begin
        case (off)
            2'b00:   lane_byte = dmem_rdata[7:0];
            2'b01:   lane_byte = dmem_rdata[15:8];
            2'b10:   lane_byte = dmem_rdata[23:16];
            default: lane_byte = dmem_rdata[31:24];
        endcase
        lane_half = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3M)
            3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_ext = {24'b0, lane_byte};
            3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_ext = {16'b0, lane_half};
            default: load_ext = dmem_rdata;
        endcase
    end

    // MEM/WB: a stall inserts a bubble and leaves the data fields untouched.
    always_comb begin
        reg_write_w_d  = reg_write_w_q;
        result_src_w_d = result_src_w_q;
        rd_w_d         = rd_w_q;
        read_data_w_d  = read_data_w_q;
        alu_result_w_d = alu_result_w_q;
        pc_plus4_w_d   = pc_plus4_w_q;
        if (StallM) begin
            reg_write_w_d  = 1'b0;
            result_src_w_d = 1'b0;
        end else begin
            reg_write_w_d  = RegWriteM & ~FaultM;
            result_src_w_d = ResultSrcM;
            rd_w_d         = RD_M;
            read_data_w_d  = load_ext;
            alu_result_w_d = ALU_ResultM;
            pc_plus4_w_d   = PCPlus4M;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_w_q  <= 1'b0;
            result_src_w_q <= 1'b0;
            rd_w_q         <= '0;
            read_data_w_q  <= '0;
            alu_result_w_q <= '0;
            pc_plus4_w_q   <= '0;
        end else begin
            reg_write_w_q  <= reg_write_w_d;
            result_src_w_q <= result_src_w_d;
            rd_w_q         <= rd_w_d;
            read_data_w_q  <= read_data_w_d;
            alu_result_w_q <= alu_result_w_d;
            pc_plus4_w_q   <= pc_plus4_w_d;
        end
    end

    assign RegWriteW   = reg_write_w_q;
    assign ResultSrcW  = result_src_w_q;
    assign RD_W        = rd_w_q;
    assign ReadDataW   = read_data_w_q;
    assign ALU_ResultW = alu_result_w_q;
    assign PCPlus4W    = pc_plus4_w_q;

endmodule
